// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, one-entry output buffer,
// redirect squashes the in-flight response and the buffered instruction.
package if_stage_pkg;
  typedef enum logic [1:0] {
    CTRL_STATE_Run     = 2'd0,
    CTRL_STATE_Stalled = 2'd1,
    CTRL_STATE_Flush   = 2'd2,
    CTRL_STATE_Bubble  = 2'd3
  } CTRL_Wire_Bus;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
endpackage

module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  CTRL_Wire_Bus ctrl_signal_i,
  input  logic         redirect_valid_i,
  input  logic [63:0]  redirect_pc_i,
  output logic         imem_req_o,
  output logic [63:0]  imem_addr_o,
  input  logic         imem_gnt_i,
  input  logic         imem_rvalid_i,
  input  logic [31:0]  imem_rdata_i,
  output logic [31:0]  if_inst_o,
  output logic [63:0]  pc_o,
  output logic         if_valid_o
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t      state_q, state_d;
  logic        started_q;
  logic [63:0] pc_q, fetch_pc;
  logic        buf_valid;
  logic [31:0] buf_inst;
  logic [63:0] buf_pc;
  logic        consume, req, fill;

  // started_q keeps the request low until the first edge after reset release
  always_comb begin
    consume = buf_valid && (ctrl_signal_i != CTRL_STATE_Stalled);
    req     = started_q && (state_q == S_REQ) && (!buf_valid || consume) && !redirect_valid_i;
    fill    = (state_q == S_WAIT) && imem_rvalid_i && !redirect_valid_i;
    state_d = state_q;
    case (state_q)
      S_REQ: begin
        if (redirect_valid_i) state_d = imem_gnt_i ? S_DROP : S_REQ;
        else if (req && imem_gnt_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid_i) state_d = imem_rvalid_i ? S_REQ : S_DROP;
        else if (imem_rvalid_i) state_d = S_REQ;
      end
      S_DROP: if (imem_rvalid_i) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_REQ;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started_q <= 1'b0;
      pc_q      <= RESET_PC;
      fetch_pc  <= '0;
      buf_valid <= 1'b0;
      buf_inst  <= NOP_INST;
      buf_pc    <= '0;
    end else begin
      started_q <= 1'b1;
      if (redirect_valid_i) begin
        pc_q      <= redirect_pc_i & ~64'h3;
        buf_valid <= 1'b0;
      end else begin
        if (req && imem_gnt_i) begin
          fetch_pc <= pc_q;
          pc_q     <= pc_q + 64'd4;
        end
        // fill only happens in WAIT, after the request that was gated on a free buffer
        if (fill) begin
          buf_valid <= 1'b1;
          buf_inst  <= imem_rdata_i;
          buf_pc    <= fetch_pc;
        end else if (consume) begin
          buf_valid <= 1'b0;
        end
      end
    end
  end

  assign imem_req_o  = req;
  assign imem_addr_o = pc_q;
  assign if_valid_o  = buf_valid;
  assign if_inst_o   = buf_valid ? buf_inst : NOP_INST;
  assign pc_o        = buf_pc;

endmodule

// File: tb/tb_if_stage.sv
// Directed table-driven bench for if_stage plus hand-written reset sequences.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam CTRL_Wire_Bus RUN = CTRL_STATE_Run;
  localparam CTRL_Wire_Bus STL = CTRL_STATE_Stalled;

  logic         clk = 1'b0;
  logic         rst;
  CTRL_Wire_Bus ctrl;
  logic         redir;
  logic [63:0]  rpc;
  logic         req;
  logic [63:0]  addr;
  logic         gnt, rvalid;
  logic [31:0]  rdata;
  logic [31:0]  inst;
  logic [63:0]  pc;
  logic         vld;

  int checks = 0;
  int errors = 0;

  if_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .ctrl_signal_i(ctrl),
    .redirect_valid_i(redir), .redirect_pc_i(rpc),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .if_inst_o(inst), .pc_o(pc), .if_valid_o(vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    CTRL_Wire_Bus ctrl;
    logic         redir;
    logic [63:0]  rpc;
    logic         gnt;
    logic         rv;
    logic [31:0]  rdata;
    logic         ereq;
    logic [63:0]  eaddr;
    logic         evld;
    logic [31:0]  einst;
    logic [63:0]  epc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(CTRL_Wire_Bus c, logic rd, logic [63:0] rp, logic g, logic rv,
                              logic [31:0] dat, logic er, logic [63:0] ea, logic ev,
                              logic [31:0] ei, logic [63:0] ep);
    vec_t v;
    v.ctrl = c; v.redir = rd; v.rpc = rp; v.gnt = g; v.rv = rv; v.rdata = dat;
    v.ereq = er; v.eaddr = ea; v.evld = ev; v.einst = ei; v.epc = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic er, input logic [63:0] ea, input logic ev,
                         input logic [31:0] ei, input logic [63:0] ep);
    chk({tag, ".req"},  {63'd0, req}, {63'd0, er});
    chk({tag, ".addr"}, addr, ea);
    chk({tag, ".vld"},  {63'd0, vld}, {63'd0, ev});
    chk({tag, ".inst"}, {32'd0, inst}, {32'd0, ei});
    chk({tag, ".pc"},   pc, ep);
  endtask

  task automatic drive(input CTRL_Wire_Bus c, input logic rd, input logic [63:0] rp,
                       input logic g, input logic rv, input logic [31:0] dat);
    ctrl = c; redir = rd; rpc = rp; gnt = g; rvalid = rv; rdata = dat;
  endtask

  initial begin
    logic [63:0] top;
    top = 64'hFFFF_FFFF_FFFF_FFFC;
    // row 0 is applied before the first edge after release: request must stay low
    vecs.push_back(mk(RUN,0,0,0,0,0,            0,RPC,0,NOP,0));
    vecs.push_back(mk(RUN,0,0,1,0,0,            1,RPC,0,NOP,0));
    vecs.push_back(mk(RUN,0,0,0,0,0,            0,RPC+4,0,NOP,0));
    vecs.push_back(mk(RUN,0,0,0,1,32'h00A00093, 0,RPC+4,0,NOP,0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(STL,0,0,1,0,0,          0,RPC+4,1,32'h00A00093,RPC));
    vecs.push_back(mk(RUN,0,0,0,0,0,            1,RPC+4,1,32'h00A00093,RPC));
    vecs.push_back(mk(RUN,0,0,1,0,0,            1,RPC+4,0,NOP,RPC));
    vecs.push_back(mk(RUN,0,0,0,1,32'h00100113, 0,RPC+8,0,NOP,RPC));
    vecs.push_back(mk(RUN,0,0,1,0,0,            1,RPC+8,1,32'h00100113,RPC+4));
    // redirect while waiting: in-flight response must vanish
    vecs.push_back(mk(RUN,1,64'h80000103,0,0,0, 0,RPC+12,0,NOP,RPC+4));
    vecs.push_back(mk(RUN,0,0,0,1,32'hDEADBEEF, 0,64'h80000100,0,NOP,RPC+4));
    vecs.push_back(mk(RUN,0,0,0,0,0,            1,64'h80000100,0,NOP,RPC+4));
    vecs.push_back(mk(RUN,0,0,1,0,0,            1,64'h80000100,0,NOP,RPC+4));
    vecs.push_back(mk(RUN,1,64'h80000200,0,1,32'h12345678, 0,64'h80000104,0,NOP,RPC+4));
    vecs.push_back(mk(RUN,0,0,1,0,0,            1,64'h80000200,0,NOP,RPC+4));
    vecs.push_back(mk(RUN,0,0,0,1,32'h00000513, 0,64'h80000204,0,NOP,RPC+4));
    // redirect coinciding with consume, then wrap at the top of the address space
    vecs.push_back(mk(RUN,1,top,0,0,0,          0,64'h80000204,1,32'h00000513,64'h80000200));
    vecs.push_back(mk(RUN,0,0,1,0,0,            1,top,0,NOP,64'h80000200));
    vecs.push_back(mk(RUN,0,0,0,1,32'h00000793, 0,64'h0,0,NOP,64'h80000200));
    vecs.push_back(mk(STL,0,0,0,1,32'hBAD0BAD0, 0,64'h0,1,32'h00000793,top));
    vecs.push_back(mk(STL,0,0,0,0,0,            0,64'h0,1,32'h00000793,top));
    vecs.push_back(mk(STL,1,64'h41,1,0,0,       0,64'h0,1,32'h00000793,top));
    vecs.push_back(mk(RUN,1,64'h82,0,0,0,       0,64'h40,0,NOP,top));
    vecs.push_back(mk(RUN,0,0,0,1,32'hBAD1BAD1, 0,64'h80,0,NOP,top));
    vecs.push_back(mk(RUN,0,0,0,0,0,            1,64'h80,0,NOP,top));

    rst = 1'b0;
    drive(RUN, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1 chk_all("reset", 0, RPC, 0, NOP, 0);

    @(negedge clk);
    rst = 1'b1;
    foreach (vecs[i]) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i].ctrl, vecs[i].redir, vecs[i].rpc, vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
      #1 chk_all($sformatf("vec%0d", i), vecs[i].ereq, vecs[i].eaddr, vecs[i].evld,
                 vecs[i].einst, vecs[i].epc);
    end

    // grant at 0x80, then reset asynchronously while the response is outstanding
    @(negedge clk);
    drive(RUN, 0, 0, 1, 0, 0);
    #1 chk_all("pre_rst_req", 1, 64'h80, 0, NOP, top);
    @(negedge clk);
    drive(RUN, 0, 0, 0, 0, 0);
    #1 chk_all("wait", 0, 64'h84, 0, NOP, top);
    #1 rst = 1'b0;
    #1 chk_all("async_rst", 0, RPC, 0, NOP, 0);

    @(negedge clk);
    rst = 1'b1;
    drive(RUN, 0, 0, 0, 1, 32'hBAD2BAD2);
    #1 chk_all("rel_stale", 0, RPC, 0, NOP, 0);
    @(negedge clk);
    drive(RUN, 0, 0, 1, 0, 0);
    #1 chk_all("first_fetch", 1, RPC, 0, NOP, 0);
    @(negedge clk);
    drive(RUN, 0, 0, 0, 0, 0);
    #1 chk_all("after_rst_wait", 0, RPC+4, 0, NOP, 0);
    @(negedge clk);
    drive(STL, 0, 0, 0, 1, 32'h00A00093);
    #1 chk_all("after_rst_rv", 0, RPC+4, 0, NOP, 0);
    @(negedge clk);
    drive(STL, 0, 0, 0, 0, 0);
    #1 chk_all("after_rst_buf", 0, RPC+4, 1, 32'h00A00093, RPC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low; asserted when 0.
REQ-004 ctrl_signal_i  in  CTRL_Wire_Bus  pipeline control; only CTRL_STATE_Stalled is acted on, every other encoding means run.
REQ-005 redirect_valid_i  in  1  one-cycle branch/jump/trap redirect pulse.
REQ-006 redirect_pc_i  in  64  redirect target, valid with redirect_valid_i.
REQ-007 imem_req_o  out  1  instruction fetch request.
REQ-008 imem_addr_o  out  64  fetch address, word aligned.
REQ-009 imem_gnt_i  in  1  request accepted this cycle.
REQ-010 imem_rvalid_i  in  1  response data valid; at least one cycle after grant, exactly one response per grant.
REQ-011 imem_rdata_i  in  32  fetched instruction.
REQ-012 if_inst_o  out  32  instruction to IF_ID; NOP (32'h0000_0013) when no valid instruction.
REQ-013 pc_o  out  64  address of if_inst_o.
REQ-014 if_valid_o  out  1  if_inst_o/pc_o carry a real fetched instruction.

Function
REQ-015 State: pc_q (next fetch address), FSM {REQ, WAIT, DROP}, one-entry buffer (buf_valid, buf_inst, buf_pc), fetch_pc (address of the outstanding request).
REQ-016 Outputs combinational from buffer: if_valid_o=buf_valid; if_inst_o=buf_valid?buf_inst:NOP; pc_o=buf_pc.
REQ-017 Consume: buffer entry is taken by IF_ID at the edge where buf_valid=1 and ctrl_signal_i!=Stalled; buf_valid clears unless refilled the same edge.
REQ-018 REQ state: imem_req_o=1 only when buf_valid=0 or consume occurs this cycle; imem_addr_o=pc_q.
REQ-019 REQ with imem_gnt_i=1 (and req high): fetch_pc<=pc_q, pc_q<=pc_q+4 (mod 2^64, wraps), state->WAIT.
REQ-020 imem_req_o and imem_addr_o stay stable until grant; no change of address while req high except via redirect.
REQ-021 WAIT with imem_rvalid_i=1: buf_inst<=imem_rdata_i, buf_pc<=fetch_pc, buf_valid<=1, state->REQ.
REQ-022 At most one outstanding request; no request issued in WAIT or DROP.
REQ-023 Stalled: buffer and outputs hold; an outstanding response is still accepted (buffer is guaranteed free by REQ-018).
REQ-024 Redirect has priority over stall and over all FSM actions: pc_q<={redirect_pc_i[63:2],2'b00}, buf_valid<=0, imem_req_o forced 0 that cycle.
REQ-025 Redirect in REQ with gnt=0: state stays REQ. With gnt=1 same cycle: state->DROP.
REQ-026 Redirect in WAIT without rvalid: state->DROP. With rvalid same cycle: response discarded, state->REQ.
REQ-027 DROP: next imem_rvalid_i discarded (buffer untouched), state->REQ; further redirects in DROP update pc_q only.
REQ-028 Redirect and consume same edge: buffer cleared; no instruction delivered twice.
REQ-029 imem_rvalid_i outside WAIT/DROP is ignored.

Reset
REQ-030 While rst=0 (asynchronous): pc_q=RESET_PC, state=REQ, buf_valid=0, buf_inst=NOP, buf_pc=0, fetch_pc=0; hence if_valid_o=0, if_inst_o=32'h0000_0013, pc_o=0, imem_req_o=0.
REQ-031 Reset asserted mid-transaction abandons the outstanding request; first request after release targets RESET_PC.
REQ-032 imem_req_o rises no earlier than the first rising edge after rst goes 1.

Verification
REQ-033 Reset release, gnt next cycle, rvalid two cycles later with 32'h00A00093 -> imem_addr_o=64'h8000_0000; then if_valid_o=1, pc_o=64'h8000_0000, if_inst_o=32'h00A00093; next request at 64'h8000_0004.
REQ-034 Buffer full, ctrl_signal_i=Stalled for 5 cycles -> outputs unchanged, imem_req_o=0; after stall drops, one consume, request for next pc issued.
REQ-035 Request at 64'h8000_0008 granted, redirect to 64'h8000_0103 before rvalid -> returned data never appears; next request at 64'h8000_0100.
REQ-036 Redirect coincident with rvalid in WAIT -> response dropped, state REQ, next address = redirect target.
REQ-037 pc_q=64'hFFFF_FFFF_FFFF_FFFC granted -> next fetch address 64'h0.
REQ-038 rst pulled low while WAIT -> all outputs at reset values immediately (before next edge); stale rvalid after release ignored, first fetch at RESET_PC.
